// File: rtl/env_pkg.sv
// Shared envelope encodings and default constants for the sequencer, the envelope and its bench.
package env_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

  localparam int ENV_SAMPLE_W      = 9;
  localparam int ENV_LEVEL_W       = 8;
  localparam int ENV_FULL          = 255;
  localparam int ENV_ATTACK_STEP   = 16;
  localparam int ENV_DECAY_STEP    = 4;
  localparam int ENV_SUSTAIN_LEVEL = 160;
  localparam int ENV_RELEASE_STEP  = 2;

endpackage

// File: rtl/env_scale.sv
// Registered sample x level multiply, keeping the top SAMPLE_W bits of the product.
module env_scale #(
  parameter int SAMPLE_W = 9,
  parameter int LEVEL_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [LEVEL_W-1:0]  level,
  output logic [SAMPLE_W-1:0] scaled
);

  localparam int PW = SAMPLE_W + LEVEL_W;

  logic [PW-1:0] prod;
  assign prod = PW'(sample) * PW'(level);

  always_ff @(posedge clk) begin
    if (reset) scaled <= '0;
    else       scaled <= SAMPLE_W'(prod >> LEVEL_W);
  end

endmodule

// File: rtl/note_envelope.sv
// Linear ADSR amplitude envelope applied to the pos/neg half-wave samples.
// Define ENV_EXP_RELEASE_EN for an exponential (level>>3) release instead of RELEASE_STEP.
module note_envelope
  import env_pkg::*;
#(
  parameter int SAMPLE_W      = ENV_SAMPLE_W,
  parameter int LEVEL_W       = ENV_LEVEL_W,
  parameter int ATTACK_STEP   = ENV_ATTACK_STEP,
  parameter int DECAY_STEP    = ENV_DECAY_STEP,
  parameter int SUSTAIN_LEVEL = ENV_SUSTAIN_LEVEL,
  parameter int RELEASE_STEP  = ENV_RELEASE_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fs_tick,
  input  logic                note_on,
  input  logic                note_off,
  input  logic [SAMPLE_W-1:0] pos_in,
  input  logic [SAMPLE_W-1:0] neg_in,
  output logic [SAMPLE_W-1:0] pos_out,
  output logic [SAMPLE_W-1:0] neg_out,
  output logic [LEVEL_W-1:0]  env_level,
  output logic [2:0]          env_state,
  output logic                busy
);

  localparam int NUM_LANES = 2;
  localparam int FULL      = (1 << LEVEL_W) - 1;
  localparam int SUS       = (SUSTAIN_LEVEL > FULL) ? FULL : SUSTAIN_LEVEL;
  // Two guard bits so level+step and sustain+step never wrap.
  localparam int XW        = LEVEL_W + 2;

  localparam logic [XW-1:0] FULL_X = XW'(FULL);
  localparam logic [XW-1:0] ATK_X  = XW'(ATTACK_STEP);
  localparam logic [XW-1:0] DEC_X  = XW'(DECAY_STEP);
  localparam logic [XW-1:0] SUS_X  = XW'(SUS);
  localparam logic [XW-1:0] REL_X  = XW'(RELEASE_STEP);

  env_state_e          state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [XW-1:0]       lvl_x, sum_x, step_x;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lvl_x   = XW'(level_q);
    sum_x   = lvl_x + ATK_X;
    step_x  = REL_X;
`ifdef ENV_EXP_RELEASE_EN
    step_x  = XW'(level_q >> 3);
    if (step_x == '0) step_x = XW'(1);
`endif
    if (note_on) begin
      state_d = ENV_ATTACK;
    end else if (note_off) begin
      if (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN}) state_d = ENV_RELEASE;
    end else if (fs_tick) begin
      unique case (state_q)
        ENV_ATTACK: begin
          if (sum_x >= FULL_X) begin
            level_d = LEVEL_W'(FULL);
            state_d = ENV_DECAY;
          end else begin
            level_d = sum_x[LEVEL_W-1:0];
          end
        end
        ENV_DECAY: begin
          if (lvl_x <= SUS_X + DEC_X) begin
            level_d = LEVEL_W'(SUS);
            state_d = ENV_SUSTAIN;
          end else begin
            level_d = level_q - DEC_X[LEVEL_W-1:0];
          end
        end
        ENV_RELEASE: begin
          if (lvl_x <= step_x) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = level_q - step_x[LEVEL_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy    <= (state_d != ENV_IDLE);
    end
  end

  assign env_state = state_q;
  assign env_level = level_q;

  // Lane 0 = positive half-wave, lane 1 = negative.
  logic [NUM_LANES-1:0][SAMPLE_W-1:0] samp_in, samp_out;
  assign samp_in = {neg_in, pos_in};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    env_scale #(.SAMPLE_W(SAMPLE_W), .LEVEL_W(LEVEL_W)) u_scale (
      .clk    (clk),
      .reset  (reset),
      .sample (samp_in[g]),
      .level  (level_q),
      .scaled (samp_out[g])
    );
  end

  assign pos_out = samp_out[0];
  assign neg_out = samp_out[1];

endmodule

// File: tb/tb_note_envelope.sv
// Scoreboard bench for note_envelope: stimulus queues expected state/level/outputs, a negedge monitor checks.
module tb_note_envelope;
  import env_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fs_tick = 1'b0, note_on = 1'b0, note_off = 1'b0;
  logic [8:0] pos_in = '0, neg_in = '0;
  logic [8:0] pos_out, neg_out;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int lv;

  typedef struct {
    string      name;
    logic [2:0] st;
    int         lvl;
    bit         chk;
    int         p;
    int         n;
  } exp_t;

  exp_t q[$];

  note_envelope dut (
    .clk       (clk),
    .reset     (reset),
    .fs_tick   (fs_tick),
    .note_on   (note_on),
    .note_off  (note_off),
    .pos_in    (pos_in),
    .neg_in    (neg_in),
    .pos_out   (pos_out),
    .neg_out   (neg_out),
    .env_level (env_level),
    .env_state (env_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input bit on, input bit off, input bit tk,
                     input logic [2:0] st, input int lvl,
                     input bit chk = 1'b0, input int p = 0, input int n = 0);
    exp_t e;
    note_on  = on;
    note_off = off;
    fs_tick  = tk;
    @(posedge clk);
    #1;
    note_on  = 1'b0;
    note_off = 1'b0;
    fs_tick  = 1'b0;
    e.name = nm; e.st = st; e.lvl = lvl; e.chk = chk; e.p = p; e.n = n;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (env_state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d want %0d", e.name, env_state, e.st);
      end
      checks++;
      if (env_level !== 8'(e.lvl)) begin
        errors++;
        $display("FAIL %s level: got %0d want %0d", e.name, env_level, e.lvl);
      end
      checks++;
      if (busy !== (e.st != 3'd0)) begin
        errors++;
        $display("FAIL %s busy: got %0b want %0b", e.name, busy, e.st != 3'd0);
      end
      if (e.chk) begin
        checks++;
        if (pos_out !== 9'(e.p)) begin
          errors++;
          $display("FAIL %s pos_out: got %0d want %0d", e.name, pos_out, e.p);
        end
        checks++;
        if (neg_out !== 9'(e.n)) begin
          errors++;
          $display("FAIL %s neg_out: got %0d want %0d", e.name, neg_out, e.n);
        end
      end
    end
  end

  initial begin
    // Reset
    pos_in = 9'd300; neg_in = 9'd200;
    cyc("reset0", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("reset1", 0, 0, 1, 0, 0, 1, 0, 0);
    reset = 1'b0;
    pos_in = '0; neg_in = '0;

    // Attack from 0
    cyc("note_on", 1, 0, 0, 1, 0);
    cyc("attack_quiet", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) cyc("attack", 0, 0, 1, 1, 16 * k);
    cyc("attack_top", 0, 0, 1, 2, 255);

    pos_in = 9'd511; neg_in = 9'd511;
    cyc("scale_full", 0, 0, 0, 2, 255, 1, 509, 509);
    pos_in = '0; neg_in = '0;

    // Decay to sustain floor
    for (int k = 1; k <= 23; k++) cyc("decay", 0, 0, 1, 2, 255 - 4 * k);
    cyc("decay_floor", 0, 0, 1, 3, 160);
    for (int k = 0; k < 3; k++) cyc("sustain_hold", 0, 0, 1, 3, 160);

    pos_in = 9'd400; neg_in = 9'd0;
    cyc("scale_160", 0, 0, 0, 3, 160, 1, 250, 0);
    pos_in = 9'd0; neg_in = 9'd300;
    cyc("scale_neg", 0, 0, 0, 3, 160, 1, 0, 187);
    pos_in = '0; neg_in = '0;

    // Release
    cyc("note_off", 0, 1, 0, 4, 160);
`ifdef ENV_EXP_RELEASE_EN
    cyc("release_first", 0, 0, 1, 4, 140);
    lv = 140;
    for (int k = 0; k < 200 && lv > 0; k++) begin
      lv = lv - (((lv >> 3) > 0) ? (lv >> 3) : 1);
      cyc("release", 0, 0, 1, (lv == 0) ? 3'd0 : 3'd4, lv);
    end
`else
    for (int k = 1; k <= 79; k++) cyc("release", 0, 0, 1, 4, 160 - 2 * k);
    cyc("release_end", 0, 0, 1, 0, 0);
`endif
    cyc("note_off_idle", 0, 1, 0, 0, 0);
    cyc("idle_tick", 0, 0, 1, 0, 0);

    // Retrigger during release
    cyc("note_on2", 1, 0, 0, 1, 0);
    for (int k = 1; k <= 7; k++) cyc("attack2", 0, 0, 1, 1, 16 * k);
    cyc("note_off2", 0, 1, 1, 4, 112);
`ifdef ENV_EXP_RELEASE_EN
    cyc("release2", 0, 0, 1, 4, 98);
    lv = 98;
`else
    for (int k = 1; k <= 6; k++) cyc("release2", 0, 0, 1, 4, 112 - 2 * k);
    lv = 100;
`endif
    cyc("retrig_tick", 1, 0, 1, 1, lv);
    lv = lv + 16;
    cyc("retrig_attack", 0, 0, 1, 1, lv);
    cyc("on_off_same", 1, 1, 1, 1, lv);
    for (int k = 0; k < 20; k++) begin
      lv = lv + 16;
      if (lv >= 255) begin
        cyc("attack3_top", 0, 0, 1, 2, 255);
        break;
      end
      cyc("attack3", 0, 0, 1, 1, lv);
    end
    for (int k = 1; k <= 23; k++) cyc("decay3", 0, 0, 1, 2, 255 - 4 * k);
    cyc("decay3_floor", 0, 0, 1, 3, 160);

    // Reset mid-note
    pos_in = 9'd256; neg_in = 9'd128;
    cyc("scale_sus", 0, 0, 0, 3, 160, 1, 160, 80);
    reset = 1'b1;
    cyc("reset_mid", 0, 0, 1, 0, 0, 1, 0, 0);
    reset = 1'b0;
    cyc("post_reset", 0, 0, 1, 0, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
